// File: rtl/adder_pkg.sv
// adder_pkg: shared flag indices, flag type and carry-lookahead block size for the adder.
`ifndef WORD
`define WORD 64
`endif

package adder_pkg;
    localparam int FLAG_N  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 0;
    localparam int CLA_BLK = 4;
    typedef logic [3:0] nzcv_t;
endpackage

// File: rtl/adder_cla4.sv
// adder_cla4: 4-bit carry-lookahead slice with group generate/propagate for the block chain.
module adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       g,
    output logic       p,
    output logic       cout
);
    logic [3:0] gi, pi, c;
    assign gi   = a & b;
    assign pi   = a ^ b;
    assign c[0] = cin;
    assign c[1] = gi[0] | (pi[0] & cin);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & cin);
    assign sum  = pi ^ c;
    assign g    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p    = &pi;
    assign cout = g | (p & cin);
endmodule

// File: rtl/adder.sv
// adder: combinational two's-complement adder with NZCV flags; ADDER_FLAGS_REG_EN registers the flags.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = `WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] add_out,
    output logic [3:0]       flags_out
);
    localparam int NB = WIDTH / CLA_BLK;
    logic [NB-1:0] blk_g, blk_p, cout_unused;
    logic [NB:0]   carry;
    nzcv_t         flags_d;

    for (genvar i = 0; i < NB; i++) begin : g_slice
        adder_cla4 u_cla (
            .a    (a_in[i*CLA_BLK +: CLA_BLK]),
            .b    (b_in[i*CLA_BLK +: CLA_BLK]),
            .cin  (carry[i]),
            .sum  (add_out[i*CLA_BLK +: CLA_BLK]),
            .g    (blk_g[i]),
            .p    (blk_p[i]),
            .cout (cout_unused[i])
        );
    end

    // Block-level carries from each slice's group generate/propagate; nothing carries into slice 0.
    always_comb begin
        carry = '0;
        for (int k = 0; k < NB; k++) carry[k+1] = blk_g[k] | (blk_p[k] & carry[k]);
    end

    // NZCV from the current sum; V is same-sign operands producing a different-sign result.
    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = add_out[WIDTH-1];
        flags_d[FLAG_Z] = ~|add_out;
        flags_d[FLAG_C] = carry[NB];
        flags_d[FLAG_V] = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (add_out[WIDTH-1] != a_in[WIDTH-1]);
    end

`ifdef ADDER_FLAGS_REG_EN
    nzcv_t flags_q;

    // Flag register loads every edge; reset wins and clears to zero.
    always_ff @(posedge clk) begin
        flags_q <= rst ? '0 : flags_d;
    end

    assign flags_out = flags_q;
`else
    logic clk_rst_unused;
    assign clk_rst_unused = clk ^ rst;
    assign flags_out      = flags_d;
`endif
endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench for adder; expected sum/flags are queued at drive time and popped at check time.
module tb_adder;
    localparam int W = 64;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a_in = '0, b_in = '0, add_out;
    logic [3:0]   flags_out;
    int           checks = 0, errors = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] sum;
        logic [3:0]   flags;
    } exp_t;
    exp_t sb[$];

    adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .add_out   (add_out),
        .flags_out (flags_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic logic [3:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {s[W-1], s[W-1:0] == '0, s[W], (a[W-1] == b[W-1]) && (s[W-1] != a[W-1])};
    endfunction

    task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] s, input logic [3:0] f);
        exp_t e;
        @(negedge clk);
        a_in = a;
        b_in = b;
        sb.push_back('{tag, s, f});
        #2;
        e = sb.pop_front();
        check({e.tag, ".sum"}, add_out, e.sum);
`ifndef ADDER_FLAGS_REG_EN
        check({e.tag, ".flags_comb"}, {60'd0, flags_out}, {60'd0, e.flags});
`endif
        @(posedge clk);
        #1;
        check({e.tag, ".flags"}, {60'd0, flags_out}, {60'd0, e.flags});
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
`ifdef ADDER_FLAGS_REG_EN
        check("reset.flags", {60'd0, flags_out}, 64'd0);
`else
        check("reset.flags", {60'd0, flags_out}, 64'h4);
`endif
        check("reset.sum", add_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        apply("c1_5p10",      64'd5,                  64'd10,   64'd15,                  4'b0000);
        apply("c2_280p1000",  64'd280,                64'd1000, 64'd1280,                4'b0000);
        apply("c3_280m1000",  64'd280,                -64'sd1000, -64'sd720,             4'b1000);
        apply("c4_m280p1000", -64'sd280,              64'd1000, 64'd720,                 4'b0010);
        apply("c5_m54321",    -64'sd54321,            64'd1000, -64'sd53321,             4'b1000);
        apply("c6_maxpos",    64'h7FFF_FFFF_FFFF_FFFF, 64'd1,   64'h8000_0000_0000_0000, 4'b1001);
        apply("wrap_ones",    '1,                     64'd1,    64'd0,                   4'b0110);
        apply("m1_m1",        '1,                     '1,       -64'sd2,                 4'b1010);
        apply("minneg_sum",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,  4'b0111);
        apply("zero_zero",    64'd0,                  64'd0,    64'd0,                   4'b0100);
        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 0) rb = ~ra + 64'd1;
            apply($sformatf("rand%0d", i), ra, rb, ra + rb, model_flags(ra, rb));
        end
`ifdef ADDER_FLAGS_REG_EN
        @(negedge clk);
        a_in = 64'h7FFF_FFFF_FFFF_FFFF;
        b_in = 64'd1;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.flags", {60'd0, flags_out}, 64'd0);
        check("midrst.sum", add_out, 64'h8000_0000_0000_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst.flags", {60'd0, flags_out}, 64'h9);
`endif
        if (sb.size() != 0) check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
